// File: rtl/raster_csr_store_if.sv
// Bus bundle for raster_csr_store: stamp batch write, slot release, CSR read request/response and occupancy.
interface raster_csr_store_if #(
  parameter int NUM_WARPS = 4,
  parameter int NUM_LANES = 4,
  parameter int DIM_BITS  = 12,
  parameter int PID_BITS  = 16
);
  localparam int WID_BITS   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int LANE_BITS  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int STAMP_BITS = 2 * (DIM_BITS - 1) + 4 + 384 + PID_BITS;

  logic                            write_valid;
  logic                            write_ready;
  logic [WID_BITS-1:0]             write_wid;
  logic [NUM_LANES-1:0]            write_tmask;
  logic [NUM_LANES*STAMP_BITS-1:0] write_stamps;
  logic                            release_valid;
  logic [WID_BITS-1:0]             release_wid;
  logic                            read_valid;
  logic [WID_BITS-1:0]             read_wid;
  logic [LANE_BITS-1:0]            read_lane;
  logic [3:0]                      read_addr;
  logic                            read_data_valid;
  logic [31:0]                     read_data;
  logic [NUM_WARPS-1:0]            occupied;

  modport master (
    output write_valid, write_wid, write_tmask, write_stamps,
    output release_valid, release_wid,
    output read_valid, read_wid, read_lane, read_addr,
    input  write_ready, read_data_valid, read_data, occupied
  );

  modport slave (
    input  write_valid, write_wid, write_tmask, write_stamps,
    input  release_valid, release_wid,
    input  read_valid, read_wid, read_lane, read_addr,
    output write_ready, read_data_valid, read_data, occupied
  );
endinterface

// File: rtl/raster_csr_store.sv
// raster_csr_store: per-warp/per-lane rasterizer stamp store, read back as 32-bit CSRs with 1-cycle latency.
// Define RASTER_CSR_BYPASS_EN to forward a same-cycle accepted write to a read of the same warp.
module raster_csr_store #(
  parameter int NUM_WARPS = 4,
  parameter int NUM_LANES = 4,
  parameter int DIM_BITS  = 12,
  parameter int PID_BITS  = 16
) (
  input logic               clk,
  input logic               reset,
  raster_csr_store_if.slave bus
);
  localparam int WID_BITS   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int POS_BITS   = DIM_BITS - 1;
  localparam int STAMP_BITS = 2 * POS_BITS + 4 + 384 + PID_BITS;
  localparam int BC_LSB     = PID_BITS;
  localparam int MASK_LSB   = PID_BITS + 384;
  localparam int PY_LSB     = MASK_LSB + 4;
  localparam int PX_LSB     = PY_LSB + POS_BITS;

  function automatic logic [31:0] csr_field(input logic [STAMP_BITS-1:0] stamp, input logic [3:0] addr);
    logic [31:0] val;
    val = 32'h0;
    case (addr)
      4'd0:        val = 32'({stamp[PY_LSB +: POS_BITS], stamp[PX_LSB +: POS_BITS], stamp[MASK_LSB +: 4]});
      4'd13:       val = 32'(stamp[0 +: PID_BITS]);
      4'd14, 4'd15: val = 32'h0;
      default:     val = stamp[BC_LSB + (int'(addr) - 1) * 32 +: 32];
    endcase
    return val;
  endfunction

  logic [STAMP_BITS-1:0] mem_q [NUM_WARPS][NUM_LANES];
  logic [NUM_WARPS-1:0]  occupied_q, occupied_d;
  logic                  read_data_valid_q, read_data_valid_d;
  logic [31:0]           read_data_q, read_data_d;

  logic                  rel_hits_write_s;
  logic                  write_ready_s;
  logic                  write_fire_s;
  logic [31:0]           rd_lane_ext_s;
  logic [STAMP_BITS-1:0] rd_entry_s;
  logic                  rd_hit_s;

  // A same-cycle release of the target slot frees it in time for the incoming batch.
  assign rel_hits_write_s = bus.release_valid && (bus.release_wid == bus.write_wid);
  assign write_ready_s    = !occupied_q[bus.write_wid] || rel_hits_write_s;
  assign write_fire_s     = bus.write_valid && write_ready_s;
  assign rd_lane_ext_s    = 32'(bus.read_lane);

  // Occupancy next state: an accepted write overrides a release of the same slot.
  always_comb begin
    occupied_d = occupied_q;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (write_fire_s && (bus.write_wid == WID_BITS'(w))) begin
        occupied_d[w] = 1'b1;
      end else if (bus.release_valid && (bus.release_wid == WID_BITS'(w))) begin
        occupied_d[w] = 1'b0;
      end else begin
        occupied_d[w] = occupied_q[w];
      end
    end
  end

  // Read-side source selection and CSR field extraction.
  always_comb begin
    rd_entry_s = mem_q[bus.read_wid][bus.read_lane];
    rd_hit_s   = occupied_q[bus.read_wid];
`ifdef RASTER_CSR_BYPASS_EN
    if (write_fire_s && (bus.write_wid == bus.read_wid)) begin
      rd_hit_s   = 1'b1;
      rd_entry_s = bus.write_tmask[bus.read_lane]
                 ? bus.write_stamps[int'(bus.read_lane) * STAMP_BITS +: STAMP_BITS]
                 : {STAMP_BITS{1'b0}};
    end else begin
      rd_hit_s   = occupied_q[bus.read_wid];
    end
`endif
    read_data_valid_d = bus.read_valid;
    if (bus.read_valid && rd_hit_s && (rd_lane_ext_s < 32'(NUM_LANES))) begin
      read_data_d = csr_field(rd_entry_s, bus.read_addr);
    end else begin
      read_data_d = 32'h0;
    end
  end

  // Control and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occupied_q        <= {NUM_WARPS{1'b0}};
      read_data_valid_q <= 1'b0;
      read_data_q       <= 32'h0;
    end else begin
      occupied_q        <= occupied_d;
      read_data_valid_q <= read_data_valid_d;
      read_data_q       <= read_data_d;
    end
  end

  // Stamp storage is deliberately left unreset; occupancy gates every read.
  always_ff @(posedge clk) begin
    for (int l = 0; l < NUM_LANES; l++) begin
      if (write_fire_s) begin
        mem_q[bus.write_wid][l] <= bus.write_tmask[l]
                                 ? bus.write_stamps[l * STAMP_BITS +: STAMP_BITS]
                                 : {STAMP_BITS{1'b0}};
      end
    end
  end

  assign bus.write_ready     = write_ready_s;
  assign bus.occupied        = occupied_q;
  assign bus.read_data_valid = read_data_valid_q;
  assign bus.read_data       = read_data_q;
endmodule

// File: tb/tb_raster_csr_store.sv
// Scoreboard bench for raster_csr_store: directed scenarios plus randomized traffic against a lane-struct model.
module tb_raster_csr_store;
  localparam int NW = 4;
  localparam int NL = 4;
  localparam int DB = 12;
  localparam int PB = 16;
  localparam int PW = DB - 1;
  localparam int SB = 2 * PW + 4 + 384 + PB;

  typedef struct packed {
    logic [PW-1:0]     px;
    logic [PW-1:0]     py;
    logic [3:0]        mask;
    logic [11:0][31:0] bc;
    logic [PB-1:0]     pid;
  } lane_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  raster_csr_store_if #(.NUM_WARPS(NW), .NUM_LANES(NL), .DIM_BITS(DB), .PID_BITS(PB)) bus ();
  raster_csr_store #(.NUM_WARPS(NW), .NUM_LANES(NL), .DIM_BITS(DB), .PID_BITS(PB)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q [$];
  logic [31:0] mon_e;
  lane_t       mdl [NW][NL];
  logic [NW-1:0] occ;

  logic        wv, rv, rdv;
  logic [1:0]  ww, rw, rdw, rl;
  logic [3:0]  tm, ra;
  lane_t       wl [NL];
  logic        force_en;
  logic [31:0] force_val;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] field(input lane_t s, input logic [3:0] a);
    if (a == 4'd0) return 32'({s.py, s.px, s.mask});
    else if (a <= 4'd12) return s.bc[a - 4'd1];
    else if (a == 4'd13) return 32'(s.pid);
    else return 32'h0;
  endfunction

  function automatic lane_t rand_lane();
    lane_t s;
    s.px = PW'($urandom);
    s.py = PW'($urandom);
    s.mask = 4'($urandom);
    for (int k = 0; k < 12; k++) s.bc[k] = $urandom;
    s.pid = PB'($urandom);
    return s;
  endfunction

  task automatic rd(input logic [1:0] w, input logic [1:0] l, input logic [3:0] a,
                    input logic fe, input logic [31:0] fv);
    rdv = 1'b1; rdw = w; rl = l; ra = a; force_en = fe; force_val = fv;
  endtask

  // One clock: drive inputs, predict, advance, check occupancy.
  task automatic cycle();
    logic exp_rdy, acc;
    logic [31:0] e;
    bus.write_valid = wv; bus.write_wid = ww; bus.write_tmask = tm;
    for (int l = 0; l < NL; l++) bus.write_stamps[l*SB +: SB] = wl[l];
    bus.release_valid = rv; bus.release_wid = rw;
    bus.read_valid = rdv; bus.read_wid = rdw; bus.read_lane = rl; bus.read_addr = ra;
    #1;
    exp_rdy = !occ[ww] || (rv && (rw == ww));
    chk("write_ready", 32'(bus.write_ready), 32'(exp_rdy));
    acc = wv && exp_rdy;
    if (rdv) begin
      if (int'(rl) >= NL) e = 32'h0;
`ifdef RASTER_CSR_BYPASS_EN
      else if (acc && (ww == rdw)) e = tm[rl] ? field(wl[rl], ra) : 32'h0;
`endif
      else if (occ[rdw]) e = field(mdl[rdw][rl], ra);
      else e = 32'h0;
      if (force_en) e = force_val;
      exp_q.push_back(e);
    end
    if (rv) occ[rw] = 1'b0;
    if (acc) begin
      occ[ww] = 1'b1;
      for (int l = 0; l < NL; l++) mdl[ww][l] = tm[l] ? wl[l] : '0;
    end
    @(posedge clk);
    #1;
    chk("occupied", 32'(bus.occupied), 32'(occ));
    if (acc) wv = 1'b0;
    rv = 1'b0; rdv = 1'b0; force_en = 1'b0;
  endtask

  // Response monitor: pops the scoreboard whenever a response strobe is seen.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.read_data_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read: got %h expected no response", bus.read_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("read_data", bus.read_data, mon_e);
        end
      end else begin
        chk("idle_data", bus.read_data, 32'h0);
      end
    end
  end

  initial begin
    reset = 1'b1;
    wv = 1'b0; rv = 1'b0; rdv = 1'b0; ww = 2'd0; rw = 2'd0; rdw = 2'd0; rl = 2'd0;
    tm = 4'h0; ra = 4'h0; force_en = 1'b0; force_val = 32'h0; occ = '0;
    for (int l = 0; l < NL; l++) wl[l] = '0;
    bus.write_valid = 1'b0; bus.write_wid = 2'd0; bus.write_tmask = 4'h0; bus.write_stamps = '0;
    bus.release_valid = 1'b0; bus.release_wid = 2'd0;
    bus.read_valid = 1'b0; bus.read_wid = 2'd0; bus.read_lane = 2'd0; bus.read_addr = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_occupied", 32'(bus.occupied), 32'h0);
    chk("rst_rdv", 32'(bus.read_data_valid), 32'h0);
    chk("rst_data", bus.read_data, 32'h0);
    chk("rst_ready", 32'(bus.write_ready), 32'h1);
    reset = 1'b0;

    // Full batch to warp 1 with known fields.
    for (int l = 0; l < NL; l++) wl[l] = rand_lane();
    wl[2].px = 11'd5; wl[2].py = 11'd9; wl[2].mask = 4'hB;
    wl[1].bc[11] = 32'hDEADBEEF; wl[1].pid = 16'h1234;
    wv = 1'b1; ww = 2'd1; tm = 4'hF;
    cycle();
    chk("occ_w1", 32'(bus.occupied), 32'h2);
    rd(2'd1, 2'd2, 4'd0, 1'b1, 32'h0004_805B);  cycle();
    rd(2'd1, 2'd1, 4'd12, 1'b1, 32'hDEADBEEF);  cycle();
    rd(2'd1, 2'd1, 4'd13, 1'b1, 32'h0000_1234); cycle();
    rd(2'd1, 2'd1, 4'd14, 1'b1, 32'h0);         cycle();
    rd(2'd1, 2'd3, 4'd5, 1'b0, 32'h0);          cycle();

    // Stall on occupied slot, then accept via same-cycle release.
    for (int l = 0; l < NL; l++) wl[l] = rand_lane();
    wv = 1'b1; ww = 2'd1; tm = 4'hF;
    for (int c = 0; c < 3; c++) begin
      rd(2'd1, 2'd2, 4'd0, 1'b1, 32'h0004_805B);
      cycle();
      chk("stall_ready", 32'(bus.write_ready), 32'h0);
    end
    rv = 1'b1; rw = 2'd1;
    cycle();
    chk("occ_after_swap", 32'(bus.occupied), 32'h2);
    rd(2'd1, 2'd0, 4'd3, 1'b0, 32'h0); cycle();

    // Partial tmask to warp 0; masked lane and free slot read as zero.
    for (int l = 0; l < NL; l++) wl[l] = rand_lane();
    wv = 1'b1; ww = 2'd0; tm = 4'b0001;
    cycle();
    rd(2'd0, 2'd3, 4'd0, 1'b1, 32'h0); cycle();
    rd(2'd2, 2'd0, 4'd0, 1'b1, 32'h0); cycle();
    rd(2'd0, 2'd0, 4'd13, 1'b0, 32'h0); cycle();

    // Same-cycle write/read forwarding on warp 0 lane 0.
    wl[0].px = 11'd7; wl[0].py = 11'd0; wl[0].mask = 4'h3;
    wv = 1'b1; ww = 2'd0; tm = 4'b0001; rv = 1'b1; rw = 2'd0;
    cycle();
    wl[0].px = 11'd1;
    wv = 1'b1; ww = 2'd0; tm = 4'b0001; rv = 1'b1; rw = 2'd0;
`ifdef RASTER_CSR_BYPASS_EN
    rd(2'd0, 2'd0, 4'd0, 1'b1, 32'h0000_0013);
`else
    rd(2'd0, 2'd0, 4'd0, 1'b1, 32'h0000_0073);
`endif
    cycle();
    // Release + write to different slots; read of released slot sees stored data.
    for (int l = 0; l < NL; l++) wl[l] = rand_lane();
    wv = 1'b1; ww = 2'd3; tm = 4'hF; rv = 1'b1; rw = 2'd1;
    cycle();
    chk("occ_diff_slots", 32'(bus.occupied), 32'h9);
    rv = 1'b1; rw = 2'd0;
    rd(2'd0, 2'd0, 4'd0, 1'b1, 32'h0000_0013);
    cycle();
    rv = 1'b1; rw = 2'd0; cycle();

    // Asynchronous reset with a response in flight.
    rd(2'd3, 2'd1, 4'd0, 1'b0, 32'h0); cycle();
    reset = 1'b1;
    #1;
    chk("mid_rst_occ", 32'(bus.occupied), 32'h0);
    chk("mid_rst_rdv", 32'(bus.read_data_valid), 32'h0);
    chk("mid_rst_data", bus.read_data, 32'h0);
    exp_q.delete();
    occ = '0; wv = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Randomized traffic; a stalled write is held until accepted.
    for (int n = 0; n < 400; n++) begin
      if (!wv && ($urandom_range(0, 2) == 0)) begin
        wv = 1'b1; ww = 2'($urandom); tm = 4'($urandom);
        for (int l = 0; l < NL; l++) wl[l] = rand_lane();
      end
      rv = ($urandom_range(0, 4) == 0); rw = 2'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        rd(($urandom_range(0, 1) == 1) ? ww : 2'($urandom), 2'($urandom), 4'($urandom), 1'b0, 32'h0);
      end
      cycle();
    end

    wv = 1'b0;
    repeat (3) cycle();
    chk("drain", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
